// File: rtl/digit_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// digit_serial_adder_pkg
//   Shared constants and types for the digit-serial adder.
//   SLICE_W : width of one digit handled per clock by the prefix-adder slice.
//   state_t : controller state encoding (2'd3 is unreachable and is treated
//             as IDLE by the controller).
// ---------------------------------------------------------------------------
package digit_serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_serial_adder_kogge_stone_4.sv
// ---------------------------------------------------------------------------
// kogge_stone_4
//   Combinational 4-bit Kogge-Stone prefix adder with carry-in.
//   Ports:
//     a, b  in  SLICE_W  addend digits
//     cin   in  1        carry into bit 0
//     sum   out SLICE_W  (a+b+cin) mod 16
//     cout  out 1        carry out of bit 3
// ---------------------------------------------------------------------------
module kogge_stone_4
  import digit_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] g1;
  logic [3:1] p1;
  logic [3:0] g2;
  logic [3:0] carry;

  always_comb begin
    p = a ^ b;
    g = a & b;
    // Fold the carry-in into bit 0's generate so the prefix tree needs no
    // extra column.
    g[0] = g[0] | (p[0] & cin);

    // distance-1 prefix level
    g1[0] = g[0];
    for (int i = 1; i < 4; i++) begin
      g1[i] = g[i] | (p[i] & g[i-1]);
      p1[i] = p[i] & p[i-1];
    end

    // distance-2 prefix level
    g2[0] = g1[0];
    g2[1] = g1[1];
    g2[2] = g1[2] | (p1[2] & g1[0]);
    g2[3] = g1[3] | (p1[3] & g1[1]);

    carry = {g2[2:0], cin};
    sum   = p ^ carry;
    cout  = g2[3];
  end

endmodule

// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------------------
// digit_serial_adder
//   WIDTH-bit adder computing a+b+cin one 4-bit digit per clock through a
//   single kogge_stone_4 slice; the inter-digit carry lives in a register.
//   Operands are accepted in IDLE, digits are processed LSB first in RUN
//   (WIDTH/4 cycles), and the result is presented in DONE until taken.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      synchronous reset, active-low
//     in_valid   in   1      operand request valid
//     in_ready   out  1      operands accepted (high only in IDLE)
//     a, b       in   WIDTH  operands, sampled on accept
//     cin        in   1      carry-in, sampled on accept
//     out_valid  out  1      result valid (high only in DONE)
//     out_ready  in   1      consumer takes result
//     sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//     cout       out  1      carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NDIG  = WIDTH / SLICE_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("digit_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry;
  logic               cout_reg;
  logic               accept;
  logic               running;
  logic [SLICE_W-1:0] a_dig;
  logic [SLICE_W-1:0] b_dig;
  logic [SLICE_W-1:0] dig_sum;
  logic               dig_cout;

  // Controller: next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    running   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        running = 1'b1;
        if (cnt == LAST_DIG) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        // unreachable encoding behaves exactly like IDLE
        in_ready  = 1'b1;
        state_nxt = in_valid ? RUN : IDLE;
      end
    endcase
    accept = in_ready & in_valid;
  end

  // Digit select: one shared slice, operands muxed by the digit counter
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_dig = a_reg[k*SLICE_W +: SLICE_W];
        b_dig = b_reg[k*SLICE_W +: SLICE_W];
      end
    end
  end

  kogge_stone_4 u_slice (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // Register stage: state, operands, digit counter, carry and result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (running) begin
        for (int k = 0; k < NDIG; k++) begin
          if (cnt == CNT_W'(k)) sum_reg[k*SLICE_W +: SLICE_W] <= dig_sum;
        end
        carry <= dig_cout;
        if (cnt == LAST_DIG) begin
          cout_reg <= dig_cout;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;

  // WIDTH=4 instance
  logic        rst4_n, in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0]  a4, b4, sum4;

  digit_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  digit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 16-bit DUT and wait for out_valid (bounded).
  // hold_valid keeps in_valid asserted with junk operands while busy.
  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c,
                      input bit hold_valid, output logic [15:0] s, output logic co,
                      output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    a = x; b = y; cin = c; in_valid = 1'b1;
    tick();
    in_valid = hold_valid;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    lat = out_valid ? n : -1;
    s   = sum;
    co  = cout;
  endtask

  task automatic release16();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic        co;
    int          lat;
    logic [16:0] q[$];
    logic [16:0] g;
    int          pushed, popped, cyc, last_vcyc, n;
    bit          saw_valid;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst4_n = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; rst4_n = 1'b1;

    // reset state
    check("reset_state", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h0000});
    check("reset_state4", {in_ready4, out_valid4, cout4, sum4}, {1'b1, 1'b0, 1'b0, 4'h0});

    // directed vector table
    foreach (vecs[i]) begin
      op16(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, lat);
      check($sformatf("vec%0d_result", i), {co, s}, {vecs[i].co, vecs[i].s});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      release16();
    end

    // backpressure with in_valid pulsed during RUN and DONE
    op16(16'hABCD, 16'h1111, 1'b0, 1'b1, s, co, lat);
    check("bp_result", {co, s, 64'(lat)}, {1'b0, 16'hBCDE, 64'd4});
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      tick();
      check("bp_hold", {in_ready, out_valid, cout, sum}, {1'b0, 1'b1, 1'b0, 16'hBCDE});
    end
    release16();
    check("idle_keeps_result", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 16'hBCDE});

    // reset mid-RUN after slice 1
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_reset", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h0000});
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); saw_valid |= out_valid; end
    check("midrun_no_valid", 64'(saw_valid), 64'd0);
    op16(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, lat);
    check("after_reset_op", {co, s, 64'(lat)}, {1'b0, 16'h5555, 64'd4});

    // reset in DONE with out_ready=1 wins
    out_ready = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b0;
    check("done_reset", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h0000});

    // back-to-back random ops against the arithmetic reference
    out_ready = 1'b1; pushed = 0; popped = 0; cyc = 0; last_vcyc = -1;
    while (popped < 1000 && cyc < 8000) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("b2b_spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          g = q.pop_front();
          check("b2b_result", {cout, sum}, g);
        end
        if (last_vcyc >= 0) check("b2b_period", 64'(cyc - last_vcyc), 64'd6);
        last_vcyc = cyc;
        popped++;
      end
      if (in_ready) begin
        if (pushed < 1000) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
          in_valid = 1'b1;
          q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
          pushed++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", 64'(popped), 64'd1000);

    // WIDTH=4 exhaustive: one-cycle RUN
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] g4;
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); in_valid4 = 1'b1;
          g4 = 5'(x + y + c);
          tick();
          in_valid4 = 1'b0;
          n = 0;
          while (!out_valid4 && n < 10) begin tick(); n++; end
          check("w4_op", {8'(n), cout4, sum4}, {8'd1, g4});
          out_ready4 = 1'b1;
          tick();
          out_ready4 = 1'b0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
